srio_nwrite_gen: RTL and testbench



---
 rtl/srio_pkg.sv | 31 +++
 rtl/srio_db_resp_mon.sv | 63 ++++++
 rtl/srio_nwrite_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_srio_nwrite_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srio_pkg.sv
// Shared definitions for the SRIO request generator: packet type codes,
// FSM state encoding and the request header packer.
package srio_pkg;

    localparam logic [3:0] FTYPE_NWRITE   = 4'h5;
    localparam logic [3:0] TTYPE_NWRITE   = 4'h4;
    localparam logic [3:0] FTYPE_DOORBELL = 4'hA;
    localparam logic [3:0] TTYPE_DOORBELL = 4'h0;
    localparam logic [3:0] FTYPE_RESP     = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NW_HDR,
        ST_NW_DATA,
        ST_DB_HDR,
        ST_DB_WAIT
    } state_t;

    // {tid, ftype, ttype, 0, prio, 0, size, 00, addr}
    function automatic logic [63:0] pack_hdr(
        input logic [7:0]  tid,
        input logic [3:0]  ftype,
        input logic [3:0]  ttype,
        input logic [1:0]  prio,
        input logic [7:0]  size,
        input logic [33:0] addr
    );
        return {tid, ftype, ttype, 1'b0, prio, 1'b0, size, 2'b00, addr};
    endfunction

endpackage

// File: rtl/srio_db_resp_mon.sv
// Doorbell response watcher: matches the response tid against the doorbell
// just sent, and flags a timeout if nothing matching arrives in time.
module srio_db_resp_mon
    import srio_pkg::*;
#(
    parameter logic [31:0] DB_TIMEOUT = 32'd100000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        arm,
    input  logic [7:0]  arm_tid,
    input  logic [11:0] iresp_hdr,
    input  logic        iresp_sof_n,
    input  logic        iresp_src_rdy_n,
    output logic        resp_hit,
    output logic        timeout,
    output logic        resp_pulse
);

    logic        armed_q, armed_d;
    logic [7:0]  tid_q, tid_d;
    logic [31:0] timer_q, timer_d;
    logic        pulse_q, pulse_d;

    always_comb begin
        resp_hit = armed_q && !iresp_sof_n && !iresp_src_rdy_n
                   && (iresp_hdr[3:0] == FTYPE_RESP) && (iresp_hdr[11:4] == tid_q);
        // A response in the final cycle still wins over the timeout
        timeout  = armed_q && !resp_hit && (timer_q == DB_TIMEOUT - 32'd1);

        armed_d = armed_q;
        tid_d   = tid_q;
        timer_d = timer_q;
        pulse_d = resp_hit;

        if (arm) begin
            armed_d = 1'b1;
            tid_d   = arm_tid;
            timer_d = 32'd0;
        end else if (resp_hit || timeout) begin
            armed_d = 1'b0;
        end else if (armed_q) begin
            timer_d = timer_q + 32'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            armed_q <= 1'b0;
            tid_q   <= 8'd0;
            timer_q <= 32'd0;
            pulse_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
            tid_q   <= tid_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
        end
    end

    assign resp_pulse = pulse_q;

endmodule

// File: rtl/srio_nwrite_gen.sv
// Builds NWRITE (payload from a FWFT FIFO) and DOORBELL requests on the SRIO
// ireq LocalLink channel and tracks doorbell responses on iresp.
module srio_nwrite_gen
    import srio_pkg::*;
#(
    parameter logic [1:0]  PRIO       = 2'd1,
    parameter logic [31:0] DB_TIMEOUT = 32'd100000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  ucfg_dest_id,
    input  logic [33:0] ucfg_dest_start_addr,
    input  logic [8:0]  ucfg_byte_count,
    input  logic [15:0] ucfg_db_info,
    input  logic        ucfg_normal_trigger,
    input  logic        ucfg_db_trigger,
    input  logic [63:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [63:0] treq_data,
    output logic        treq_sof_n,
    output logic        treq_eof_n,
    output logic        treq_src_rdy_n,
    input  logic        treq_dst_rdy_n,
    output logic [7:0]  treq_dest_id,
    input  logic [63:0] iresp_data,
    input  logic        iresp_sof_n,
    input  logic        iresp_src_rdy_n,
    output logic        iresp_dst_rdy_n,
    output logic        srio_initial_busy,
    output logic        srio_db_resp,
    output logic [31:0] error_conter
);

    state_t      state_q, state_d;
    logic [7:0]  tid_q, tid_d;
    logic [7:0]  dest_q, dest_d;
    logic [33:0] addr_q, addr_d;
    logic [7:0]  size_q, size_d;
    logic [5:0]  beats_q, beats_d;
    logic [15:0] db_info_q, db_info_d;
    logic [7:0]  db_dest_q, db_dest_d;
    logic        db_pending_q, db_pending_d;
    logic [31:0] err_q, err_d;
    logic        busy_q, busy_d;

    logic        accept_nw;
    logic        db_arm;
    logic        resp_hit;
    logic        resp_timeout;
    logic        resp_pulse;
    logic        e_nw, e_db, e_to;
    logic [9:0]  bc_round;
    logic [32:0] err_sum;
    logic [63:0] nw_hdr, db_hdr;
    logic        unused_iresp;

    assign unused_iresp = ^iresp_data[51:0];

    srio_db_resp_mon #(
        .DB_TIMEOUT (DB_TIMEOUT)
    ) u_resp_mon (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .arm             (db_arm),
        .arm_tid         (tid_q),
        .iresp_hdr       (iresp_data[63:52]),
        .iresp_sof_n     (iresp_sof_n),
        .iresp_src_rdy_n (iresp_src_rdy_n),
        .resp_hit        (resp_hit),
        .timeout         (resp_timeout),
        .resp_pulse      (resp_pulse)
    );

    always_comb begin
        state_d      = state_q;
        tid_d        = tid_q;
        dest_d       = dest_q;
        addr_d       = addr_q;
        size_d       = size_q;
        beats_d      = beats_q;
        db_info_d    = db_info_q;
        db_dest_d    = db_dest_q;
        db_pending_d = db_pending_q;
        db_arm       = 1'b0;
        e_nw         = 1'b0;
        e_db         = 1'b0;
        e_to         = 1'b0;

        treq_data      = 64'd0;
        treq_sof_n     = 1'b1;
        treq_eof_n     = 1'b1;
        treq_src_rdy_n = 1'b1;
        fifo_rd_en     = 1'b0;

        nw_hdr   = pack_hdr(tid_q, FTYPE_NWRITE, TTYPE_NWRITE, PRIO, size_q, addr_q);
        db_hdr   = pack_hdr(tid_q, FTYPE_DOORBELL, TTYPE_DOORBELL, PRIO, 8'd0,
                            {18'd0, db_info_q});
        bc_round = {1'b0, ucfg_byte_count} + 10'd7;

        accept_nw = (state_q == ST_IDLE) && !db_pending_q && ucfg_normal_trigger
                    && (ucfg_byte_count != 9'd0);
        if (ucfg_normal_trigger && !accept_nw) begin
            e_nw = 1'b1;
        end

        // db_pending covers the doorbell from trigger until its header beat leaves
        if (ucfg_db_trigger) begin
            if (db_pending_q) begin
                e_db = 1'b1;
            end else begin
                db_pending_d = 1'b1;
                db_info_d    = ucfg_db_info;
                db_dest_d    = ucfg_dest_id;
            end
        end

        if (accept_nw) begin
            dest_d  = ucfg_dest_id;
            addr_d  = ucfg_dest_start_addr;
            size_d  = 8'(ucfg_byte_count - 9'd1);
            beats_d = bc_round[8:3];
            state_d = ST_NW_HDR;
        end

        case (state_q)
            ST_IDLE: begin
                if (!accept_nw && db_pending_d) begin
                    dest_d  = db_dest_d;
                    state_d = ST_DB_HDR;
                end
            end
            ST_NW_HDR: begin
                treq_data      = nw_hdr;
                treq_sof_n     = 1'b0;
                treq_src_rdy_n = 1'b0;
                if (!treq_dst_rdy_n) begin
                    state_d = ST_NW_DATA;
                end
            end
            ST_NW_DATA: begin
                treq_data      = fifo_dout;
                treq_src_rdy_n = fifo_empty;
                treq_eof_n     = (beats_q != 6'd1);
                fifo_rd_en     = !fifo_empty && !treq_dst_rdy_n;
                if (fifo_rd_en) begin
                    beats_d = beats_q - 6'd1;
                    if (beats_q == 6'd1) begin
                        tid_d = tid_q + 8'd1;
                        if (db_pending_d) begin
                            dest_d  = db_dest_d;
                            state_d = ST_DB_HDR;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_DB_HDR: begin
                treq_data      = db_hdr;
                treq_sof_n     = 1'b0;
                treq_eof_n     = 1'b0;
                treq_src_rdy_n = 1'b0;
                if (!treq_dst_rdy_n) begin
                    db_arm       = 1'b1;
                    tid_d        = tid_q + 8'd1;
                    db_pending_d = 1'b0;
                    state_d      = ST_DB_WAIT;
                end
            end
            ST_DB_WAIT: begin
                if (resp_hit) begin
                    state_d = ST_IDLE;
                end else if (resp_timeout) begin
                    e_to    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Several error sources can fire together; count all, saturating
        err_sum = {1'b0, err_q} + 33'(e_nw) + 33'(e_db) + 33'(e_to);
        err_d   = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];

        busy_d = (state_d != ST_IDLE) || db_pending_d;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            tid_q        <= 8'd0;
            dest_q       <= 8'd0;
            addr_q       <= 34'd0;
            size_q       <= 8'd0;
            beats_q      <= 6'd0;
            db_info_q    <= 16'd0;
            db_dest_q    <= 8'd0;
            db_pending_q <= 1'b0;
            err_q        <= 32'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tid_q        <= tid_d;
            dest_q       <= dest_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            beats_q      <= beats_d;
            db_info_q    <= db_info_d;
            db_dest_q    <= db_dest_d;
            db_pending_q <= db_pending_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign treq_dest_id      = dest_q;
    assign iresp_dst_rdy_n   = 1'b0;
    assign srio_initial_busy = busy_q;
    assign srio_db_resp      = resp_pulse;
    assign error_conter      = err_q;

endmodule

// File: tb/tb_srio_nwrite_gen.sv
// Scoreboard bench for srio_nwrite_gen: expected ireq beats are queued when a
// trigger is driven and popped as the DUT transfers them.
module tb_srio_nwrite_gen;

    localparam logic [31:0] TO = 32'd50;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  ucfg_dest_id = 8'd0;
    logic [33:0] ucfg_dest_start_addr = 34'd0;
    logic [8:0]  ucfg_byte_count = 9'd0;
    logic [15:0] ucfg_db_info = 16'd0;
    logic        ucfg_normal_trigger = 1'b0;
    logic        ucfg_db_trigger = 1'b0;
    logic [63:0] fifo_dout = 64'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [63:0] treq_data;
    logic        treq_sof_n, treq_eof_n, treq_src_rdy_n;
    logic        treq_dst_rdy_n = 1'b0;
    logic [7:0]  treq_dest_id;
    logic [63:0] iresp_data = 64'd0;
    logic        iresp_sof_n = 1'b1;
    logic        iresp_src_rdy_n = 1'b1;
    logic        iresp_dst_rdy_n;
    logic        srio_initial_busy, srio_db_resp;
    logic [31:0] error_conter;

    srio_nwrite_gen #(
        .PRIO       (2'd1),
        .DB_TIMEOUT (TO)
    ) dut (
        .sys_clk              (sys_clk),
        .sys_rst_n            (sys_rst_n),
        .ucfg_dest_id         (ucfg_dest_id),
        .ucfg_dest_start_addr (ucfg_dest_start_addr),
        .ucfg_byte_count      (ucfg_byte_count),
        .ucfg_db_info         (ucfg_db_info),
        .ucfg_normal_trigger  (ucfg_normal_trigger),
        .ucfg_db_trigger      (ucfg_db_trigger),
        .fifo_dout            (fifo_dout),
        .fifo_empty           (fifo_empty),
        .fifo_rd_en           (fifo_rd_en),
        .treq_data            (treq_data),
        .treq_sof_n           (treq_sof_n),
        .treq_eof_n           (treq_eof_n),
        .treq_src_rdy_n       (treq_src_rdy_n),
        .treq_dst_rdy_n       (treq_dst_rdy_n),
        .treq_dest_id         (treq_dest_id),
        .iresp_data           (iresp_data),
        .iresp_sof_n          (iresp_sof_n),
        .iresp_src_rdy_n      (iresp_src_rdy_n),
        .iresp_dst_rdy_n      (iresp_dst_rdy_n),
        .srio_initial_busy    (srio_initial_busy),
        .srio_db_resp         (srio_db_resp),
        .error_conter         (error_conter)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [63:0] data;
        logic        sof_n;
        logic        eof_n;
        logic [7:0]  dest;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] fq[$];
    int          checks = 0;
    int          errors = 0;
    int          resp_cnt = 0;
    int          data_seen = 0;
    logic        stall = 1'b0;
    logic        pop_req = 1'b0;
    logic        toggle_rdy = 1'b0;
    logic [7:0]  tid_m = 8'd0;
    logic [31:0] err_m = 32'd0;
    logic        mon_xfer;
    beat_t       mon_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] tid, input logic [3:0] ft,
                                        input logic [3:0] tt, input logic [7:0] size,
                                        input logic [33:0] addr);
        logic [63:0] h;
        h          = 64'd0;
        h[63:56]   = tid;
        h[55:52]   = ft;
        h[51:48]   = tt;
        h[46:45]   = 2'd1;
        h[43:36]   = size;
        h[33:0]    = addr;
        return h;
    endfunction

    task automatic fifo_refresh();
        fifo_empty = (fq.size() == 0) || stall;
        if (fq.size() != 0) fifo_dout = fq[0];
        else                fifo_dout = 64'd0;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic push_beat(input logic [63:0] d, input logic s, input logic e, input logic [7:0] dest);
        beat_t b;
        b.data = d; b.sof_n = s; b.eof_n = e; b.dest = dest;
        exp_q.push_back(b);
    endtask

    // Queue the expected packet(s), fill the FIFO and pulse the trigger(s)
    task automatic nwrite(input logic [7:0] dest, input logic [33:0] addr, input int bc,
                          input bit with_db, input logic [15:0] info);
        int nb;
        logic [63:0] w;
        nb = (bc + 7) / 8;
        push_beat(hdr(tid_m, 4'h5, 4'h4, 8'(bc - 1), addr), 1'b0, 1'b1, dest);
        for (int i = 0; i < nb; i++) begin
            w = {$urandom, $urandom};
            fq.push_back(w);
            push_beat(w, 1'b1, (i == nb - 1) ? 1'b0 : 1'b1, dest);
        end
        tid_m++;
        if (with_db) begin
            push_beat(hdr(tid_m, 4'hA, 4'h0, 8'd0, {18'd0, info}), 1'b0, 1'b0, dest);
            tid_m++;
        end
        fifo_refresh();
        ucfg_dest_id         = dest;
        ucfg_dest_start_addr = addr;
        ucfg_byte_count      = 9'(bc);
        ucfg_db_info         = info;
        ucfg_normal_trigger  = 1'b1;
        ucfg_db_trigger      = with_db;
        tick();
        ucfg_normal_trigger  = 1'b0;
        ucfg_db_trigger      = 1'b0;
    endtask

    task automatic doorbell(input logic [7:0] dest, input logic [15:0] info);
        push_beat(hdr(tid_m, 4'hA, 4'h0, 8'd0, {18'd0, info}), 1'b0, 1'b0, dest);
        tid_m++;
        ucfg_dest_id    = dest;
        ucfg_db_info    = info;
        ucfg_db_trigger = 1'b1;
        tick();
        ucfg_db_trigger = 1'b0;
    endtask

    task automatic respond(input logic [7:0] tid);
        iresp_data      = {tid, 4'hD, 52'd0};
        iresp_sof_n     = 1'b0;
        iresp_src_rdy_n = 1'b0;
        tick();
        iresp_sof_n     = 1'b1;
        iresp_src_rdy_n = 1'b1;
        iresp_data      = 64'd0;
    endtask

    task automatic wait_drain(input string tag, input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sof_n"}, treq_sof_n, 1'b1);
        check({tag, "_eof_n"}, treq_eof_n, 1'b1);
        check({tag, "_src_rdy_n"}, treq_src_rdy_n, 1'b1);
        check({tag, "_data"}, treq_data, 64'd0);
        check({tag, "_dest"}, treq_dest_id, 8'd0);
        check({tag, "_rd_en"}, fifo_rd_en, 1'b0);
        check({tag, "_busy"}, srio_initial_busy, 1'b0);
        check({tag, "_db_resp"}, srio_db_resp, 1'b0);
        check({tag, "_err"}, error_conter, 32'd0);
    endtask

    // Mid-cycle monitor: everything here is what the next rising edge will capture
    always @(negedge sys_clk) begin
        mon_xfer = !treq_src_rdy_n && !treq_dst_rdy_n;
        if (fifo_rd_en) begin
            check("rd_en_on_data_xfer", {63'd0, mon_xfer && treq_sof_n}, 64'd1);
            pop_req = 1'b1;
        end
        if (mon_xfer) begin
            $display("beat sof_n=%b eof_n=%b dest=%h data=%h",
                     treq_sof_n, treq_eof_n, treq_dest_id, treq_data);
            if (treq_sof_n) data_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", treq_data, mon_e.data);
                check("beat_sof_n", treq_sof_n, mon_e.sof_n);
                check("beat_eof_n", treq_eof_n, mon_e.eof_n);
                check("beat_dest", treq_dest_id, mon_e.dest);
            end
        end
        if (srio_db_resp) resp_cnt++;
    end

    always @(posedge sys_clk) begin
        #1;
        if (pop_req) begin
            if (fq.size() != 0) void'(fq.pop_front());
            pop_req = 1'b0;
        end
        fifo_refresh();
    end

    always @(posedge sys_clk) begin
        #1;
        if (toggle_rdy) treq_dst_rdy_n = ~treq_dst_rdy_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        fifo_refresh();
        repeat (3) tick();
        check_idle_outputs("reset");
        sys_rst_n = 1'b1;
        tick();

        // Plain NWRITE, 64 bytes, tid 0
        nwrite(8'h0A, 34'h1_0000_0100, 64, 1'b0, 16'd0);
        check("nw1_hdr_latency", treq_data, 64'h005423F100000100);
        check("nw1_hdr_sof_n", treq_sof_n, 1'b0);
        check("nw1_busy", srio_initial_busy, 1'b1);
        check("nw1_dest", treq_dest_id, 8'h0A);
        wait_drain("nw1_drain", 100);
        check("nw1_busy_after_eof", srio_initial_busy, 1'b0);

        // Doorbell, tid 1
        doorbell(8'h0B, 16'h1234);
        check("db1_hdr", treq_data, 64'h01A0200000001234);
        check("db1_sof_n", treq_sof_n, 1'b0);
        check("db1_eof_n", treq_eof_n, 1'b0);
        wait_drain("db1_drain", 20);
        respond(8'h00);
        tick();
        check("db1_wrong_tid_resp", 64'(resp_cnt), 64'd0);
        check("db1_wrong_tid_busy", srio_initial_busy, 1'b1);
        respond(8'h01);
        check("db1_resp_pulse", srio_db_resp, 1'b1);
        check("db1_busy_clear", srio_initial_busy, 1'b0);
        tick();
        check("db1_resp_one_cycle", srio_db_resp, 1'b0);
        check("db1_resp_count", 64'(resp_cnt), 64'd1);

        // NWRITE with back-pressure and a FIFO stall mid-packet, tid 2
        toggle_rdy = 1'b1;
        nwrite(8'h0A, 34'h1_0000_0100, 64, 1'b0, 16'd0);
        repeat (4) tick();
        stall = 1'b1;
        fifo_refresh();
        repeat (5) tick();
        stall = 1'b0;
        fifo_refresh();
        wait_drain("nw2_drain", 200);
        toggle_rdy = 1'b0;
        tick();
        treq_dst_rdy_n = 1'b0;
        check("nw2_fifo_consumed", 64'(fq.size()), 64'd0);
        check("nw2_busy", srio_initial_busy, 1'b0);

        // Doorbell that never gets a response, tid 3
        doorbell(8'h0C, 16'hBEEF);
        tick();
        check("db2_sent", 64'(exp_q.size()), 64'd0);
        repeat (TO - 1) tick();
        check("db2_err_before_timeout", error_conter, err_m);
        tick();
        err_m++;
        check("db2_err_at_timeout", error_conter, err_m);
        check("db2_no_resp", 64'(resp_cnt), 64'd1);
        check("db2_busy", srio_initial_busy, 1'b0);

        // Both triggers together (NWRITE tid 4, doorbell tid 5), plus a rejected trigger
        stall = 1'b1;
        fifo_refresh();
        nwrite(8'h0D, 34'h0_0000_2000, 8, 1'b1, 16'h5555);
        tick();
        ucfg_byte_count     = 9'd8;
        ucfg_normal_trigger = 1'b1;
        tick();
        ucfg_normal_trigger = 1'b0;
        err_m++;
        check("busy_trigger_err", error_conter, err_m);
        stall = 1'b0;
        fifo_refresh();
        wait_drain("both_drain", 50);
        check("both_busy_in_wait", srio_initial_busy, 1'b1);
        respond(tid_m - 8'd1);
        check("both_resp_pulse", srio_db_resp, 1'b1);
        tick();
        check("both_busy", srio_initial_busy, 1'b0);

        // Zero byte count while idle
        ucfg_byte_count     = 9'd0;
        ucfg_normal_trigger = 1'b1;
        tick();
        ucfg_normal_trigger = 1'b0;
        err_m++;
        check("zero_bc_err", error_conter, err_m);
        repeat (5) tick();
        check("zero_bc_busy", srio_initial_busy, 1'b0);
        check("zero_bc_no_pkt", treq_src_rdy_n, 1'b1);

        // Reset during the 4th data beat
        data_seen = 0;
        nwrite(8'h0E, 34'h3_0000_0000, 64, 1'b0, 16'd0);
        for (int n = 0; n < 50 && data_seen < 3; n++) tick();
        check("rst_reached_beat4", 64'(data_seen), 64'd3);
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        check_idle_outputs("midrst");
        exp_q.delete();
        fq.delete();
        fifo_refresh();
        tid_m = 8'd0;
        err_m = 32'd0;
        nwrite(8'h0E, 34'h0_0000_0040, 16, 1'b0, 16'd0);
        check("post_rst_tid", treq_data[63:56], 8'h00);
        wait_drain("post_rst_drain", 50);
        check("post_rst_busy", srio_initial_busy, 1'b0);
        check("post_rst_err", error_conter, err_m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
